// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects raw push-button pins.
// Each channel owns a 2-FF synchroniser, a stable-cycle counter and a four-state FSM.
module button_conditioner #(
    parameter int NUM_BUTTONS    = 2,
    parameter int DEBOUNCE_COUNT = 240000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btn_in,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);
    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          sync1_q, sync2_q;
        logic          level_q, press_q, release_q;
        logic          press_d, release_d;
        logic          active, done;

        assign active = sync2_q ^ ACTIVE_LOW;
        assign done   = cnt_q == CW'(DEBOUNCE_COUNT - 1);

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                IDLE:         if (active) state_d = PRESS_WAIT;
                PRESS_WAIT:   if (!active) state_d = IDLE;
                              else if (done) begin state_d = PRESSED; press_d = 1'b1; end
                              else cnt_d = cnt_q + CW'(1);
                PRESSED:      if (!active) state_d = RELEASE_WAIT;
                RELEASE_WAIT: if (active) state_d = PRESSED;
                              else if (done) begin state_d = IDLE; release_d = 1'b1; end
                              else cnt_d = cnt_q + CW'(1);
                default:      state_d = IDLE;
            endcase
            // Every transition restarts the stability count, so it can never wrap.
            if (state_d != state_q) cnt_d = '0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q   <= ACTIVE_LOW;
                sync2_q   <= ACTIVE_LOW;
                state_q   <= IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1_q   <= btn_in[i];
                sync2_q   <= sync1_q;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus feeding a pulse scoreboard, with a decoupled monitor.
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_in = 2'b11;
    logic [1:0] btn_level, btn_press, btn_release;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        int         c;
        logic [1:0] p;
        logic [1:0] r;
        logic [1:0] l;
    } ev_t;
    ev_t sb[$];

    button_conditioner #(.NUM_BUTTONS(2), .DEBOUNCE_COUNT(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
        sb.push_back('{c, p, r, l});
    endtask

    task automatic chk_all_zero(input string n);
        chk(n, int'({btn_level, btn_press, btn_release}), 0);
    endtask

    // Monitor: every press/release pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if ((btn_press | btn_release) != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", int'({btn_press, btn_release}), 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.c);
                chk("pulse_press", int'(btn_press), int'(e.p));
                chk("pulse_release", int'(btn_release), int'(e.r));
                chk("pulse_level", int'(btn_level), int'(e.l));
            end
        end
    end

    initial begin
        int t0;
        step(3);
        chk_all_zero("reset_state");
        rst = 1'b0;
        step(2);

        // Clean press on channel 0
        t0 = cyc;
        btn_in[0] = 1'b0;
        expect_ev(t0 + 7, 2'b01, 2'b00, 2'b01);
        step(6);
        chk("press_level_early", int'(btn_level), 0);
        step(1);
        chk("press_level", int'(btn_level), 1);
        chk("press_pulse", int'(btn_press), 1);
        step(1);
        chk("press_pulse_end", int'(btn_press), 0);
        chk("press_level_hold", int'(btn_level), 1);

        // Short release glitch while pressed
        btn_in[0] = 1'b1;
        step(2);
        btn_in[0] = 1'b0;
        step(10);
        chk("glitch_level", int'(btn_level), 1);

        // Clean release
        t0 = cyc;
        btn_in[0] = 1'b1;
        expect_ev(t0 + 7, 2'b00, 2'b01, 2'b00);
        step(6);
        chk("release_level_early", int'(btn_level), 1);
        step(1);
        chk("release_level", int'(btn_level), 0);
        chk("release_pulse", int'(btn_release), 1);
        step(1);
        chk("release_pulse_end", int'(btn_release), 0);

        // Bounce: 3 cycles pressed / 3 released, never stable long enough
        for (int k = 0; k < 20; k++) begin
            btn_in[0] = ((k / 3) % 2) != 0;
            step(1);
        end
        btn_in[0] = 1'b1;
        step(10);
        chk("bounce_level", int'(btn_level), 0);

        // Simultaneous press then release of both channels
        t0 = cyc;
        btn_in = 2'b00;
        expect_ev(t0 + 7, 2'b11, 2'b00, 2'b11);
        step(7);
        chk("simul_press", int'(btn_press), 3);
        step(1);
        chk("simul_press_end", int'(btn_press), 0);
        t0 = cyc;
        btn_in = 2'b11;
        expect_ev(t0 + 7, 2'b00, 2'b11, 2'b00);
        step(8);
        chk("simul_idle", int'(btn_level), 0);

        // Reset in the middle of a press wait on channel 1
        btn_in[1] = 1'b0;
        step(5);
        rst = 1'b1;
        step(1);
        chk_all_zero("midwait_reset");
        rst = 1'b0;
        t0 = cyc;
        expect_ev(t0 + 7, 2'b10, 2'b00, 2'b10);
        step(6);
        chk("midwait_level_early", int'(btn_level), 0);
        step(1);
        chk("midwait_press", int'(btn_press), 2);
        chk("midwait_level", int'(btn_level), 2);
        t0 = cyc;
        btn_in[1] = 1'b1;
        expect_ev(t0 + 7, 2'b00, 2'b10, 2'b00);
        step(8);

        // Button held through a long reset
        btn_in[0] = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk_all_zero("held_reset");
        end
        rst = 1'b0;
        t0 = cyc;
        expect_ev(t0 + 7, 2'b01, 2'b00, 2'b01);
        step(12);
        chk("held_level", int'(btn_level), 1);
        t0 = cyc;
        btn_in[0] = 1'b1;
        expect_ev(t0 + 7, 2'b00, 2'b01, 2'b00);
        step(10);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
